// File: rtl/sevenseg_pkg.sv
// Shared constants and types for seven-segment display blocks.
// Segment vectors are {g,f,e,d,c,b,a}, active low (0 = segment lit).
package sevenseg_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_e;

  // Observable scan state: current slot and its phase.
  typedef struct packed {
    logic [1:0] idx;
    phase_e     phase;
  } scan_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with per-slot blanking,
// leading-zero suppression and frame snapshotting of the inputs.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          tick, snap;

  logic [15:0]   dig_sh_q;
  logic [3:0]    dp_sh_q, en_sh_q;
  logic          lzb_sh_q;

  logic [3:0]    lz;
  logic [3:0]    cur_digit;
  logic [6:0]    seg_dec;
  logic          lit;
  scan_state_t   st;

  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d, fs_d;

  always_comb begin
    tick   = (pcnt_q == PW'(REFRESH_DIV - 1));
    snap   = tick && (idx_q == 2'd3);
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    bcnt_d = bcnt_q;
    if (tick) begin
      bcnt_d = BW'(BLANK_CYCLES);
    end else if (bcnt_q != '0) begin
      bcnt_d = bcnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
      idx_q  <= 2'd3;
      bcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      bcnt_q <= bcnt_d;
    end
  end

  // Shadow copy taken only at the 3->0 wrap so a frame never mixes old and new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig_sh_q <= '0;
      dp_sh_q  <= '0;
      en_sh_q  <= '0;
      lzb_sh_q <= 1'b0;
    end else if (snap) begin
      dig_sh_q <= digits_in;
      dp_sh_q  <= dp_in;
      en_sh_q  <= digit_en;
      lzb_sh_q <= lz_blank;
    end
  end

  always_comb begin
    lz[3] = lzb_sh_q & (dig_sh_q[15:12] == 4'd0);
    lz[2] = lz[3] & (dig_sh_q[11:8] == 4'd0);
    lz[1] = lz[2] & (dig_sh_q[7:4] == 4'd0);
    lz[0] = 1'b0;
  end

  always_comb begin
    st.idx    = idx_q;
    st.phase  = (bcnt_q != '0) ? PH_BLANK : PH_SHOW;
    cur_digit = dig_sh_q[{idx_q, 2'b00} +: 4];
  end

  bcd_to_7seg u_dec (
    .bcd_i (cur_digit),
    .seg_o (seg_dec)
  );

  always_comb begin
    lit   = (st.phase == PH_SHOW) && en_sh_q[st.idx] && !lz[st.idx];
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << st.idx);
      seg_d = seg_dec;
      dp_d  = ~dp_sh_q[st.idx];
    end
    // Counter state (pcnt=0, idx=0) exists only right after a snapshot edge.
    fs_d = (pcnt_q == '0) && (idx_q == 2'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_sevenseg_scan_driver;

  localparam int NV = 9;

  // Vector: inputs plus hand-derived expectations. segs[s] / lit[s] / dpo[s] refer to slot s.
  typedef struct packed {
    logic [15:0]      digits;
    logic [3:0]       dpi;
    logic [3:0]       en;
    logic             lzb;
    logic [3:0][6:0]  segs;
    logic [3:0]       lit;
    logic [3:0]       dpo;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int checks = 0;
  int failures = 0;
  int tag_frame = -1;
  int tag_cyc = 0;

  logic [12:0] exp_q[$];   // {an, seg, dp, frame_start}
  vec_t        vecs[NV];

  localparam logic [12:0] DARK = {4'b1111, 7'b1111111, 1'b1, 1'b0};

  sevenseg_scan_driver #(
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .lz_blank    (lz_blank),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive(input vec_t v);
    digits_in = v.digits;
    dp_in     = v.dpi;
    digit_en  = v.en;
    lz_blank  = v.lzb;
  endtask

  task automatic push_dark(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(DARK);
  endtask

  // Expected output stream for one frame: 4 slots x (2 blank + 6 show) cycles.
  task automatic push_frame(input vec_t v, input int ncyc);
    int cnt;
    logic [12:0] e;
    logic [3:0]  an_e;
    cnt = 0;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        e = DARK;
        if (c >= 2 && v.lit[s]) begin
          an_e = 4'b1111;
          an_e[s] = 1'b0;
          e = {an_e, v.segs[s], ~v.dpo[s], 1'b0};
        end
        if (s == 0 && c == 0) e[0] = 1'b1;
        if (cnt < ncyc) exp_q.push_back(e);
        cnt++;
      end
    end
  endtask

  task automatic compare(input logic [12:0] e, input string name);
    logic [12:0] a;
    a = {an, seg, dp, frame_start};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s frame=%0d cyc=%0d got an=%b seg=%b dp=%b fs=%b want an=%b seg=%b dp=%b fs=%b",
               name, tag_frame, tag_cyc, a[12:9], a[8:2], a[1], a[0], e[12:9], e[8:2], e[1], e[0]);
    end
  endtask

  task automatic check_cycle();
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_underflow frame=%0d cyc=%0d", tag_frame, tag_cyc);
    end else begin
      compare(exp_q.pop_front(), "stream");
    end
    tag_cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) check_cycle();
  endtask

  initial begin
    //                 digits    dpi     en      lzb   segs {s3,s2,s1,s0}                                       lit     dpo
    vecs[0] = '{16'h1234, 4'b0000, 4'b1111, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111, 4'b0000};
    vecs[1] = '{16'h0050, 4'b0000, 4'b1111, 1'b1, {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b0011, 4'b0000};
    vecs[2] = '{16'h0000, 4'b0000, 4'b1111, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b0001, 4'b0000};
    vecs[3] = '{16'h00B0, 4'b0100, 4'b1111, 1'b0, {7'b1000000, 7'b1000000, 7'b0111111, 7'b1000000}, 4'b1111, 4'b0100};
    vecs[4] = '{16'h1111, 4'b0000, 4'b1111, 1'b0, {7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001}, 4'b1111, 4'b0000};
    vecs[5] = '{16'h2222, 4'b0000, 4'b1111, 1'b0, {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100}, 4'b1111, 4'b0000};
    vecs[6] = '{16'h9876, 4'b1001, 4'b1010, 1'b0, {7'b0010000, 7'b1111111, 7'b1111000, 7'b1111111}, 4'b1010, 4'b1000};
    vecs[7] = '{16'h0105, 4'b0000, 4'b1111, 1'b1, {7'b1111111, 7'b1111001, 7'b1000000, 7'b0010010}, 4'b0111, 4'b0000};
    vecs[8] = '{16'h8000, 4'b1111, 4'b1111, 1'b1, {7'b0000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111, 4'b1111};

    // Reset held for 3 cycles; outputs must be dark throughout.
    reset = 1'b1;
    drive('0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare(DARK, "in_reset");
    end
    reset = 1'b0;

    // Inputs ahead of the first snapshot are invisible until the first tick.
    drive(vecs[0]);
    push_dark(8);
    run(8);

    // Next vector changes mid-frame (slot1 show); the frame on display must not tear.
    for (int k = 0; k < NV; k++) begin
      tag_frame = k;
      tag_cyc = 0;
      push_frame(vecs[k], 32);
      run(12);
      if (k + 1 < NV) drive(vecs[k + 1]);
      run(20);
    end

    // Run into slot2's lit phase, then reset between clock edges.
    tag_frame = 100;
    tag_cyc = 0;
    push_frame(vecs[NV-1], 21);
    run(21);
    #1 reset = 1'b1;
    #1 compare(DARK, "async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare(DARK, "in_reset2");
    end
    reset = 1'b0;

    // Restart timing matches power-up: 8 dark cycles, then a full frame.
    tag_frame = 101;
    tag_cyc = 0;
    push_dark(8);
    push_frame(vecs[NV-1], 32);
    run(40);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
